// File: rtl/message_pkg.sv
// Shared constants and helpers for the message slicer/stitcher pair.
package message_pkg;

    // Ceiling log2 for sizing counters and pointers at elaboration time.
    function automatic int clog2(input int value);
        int result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Show-ahead word FIFO: the head word sits on read_data while read_valid is high.
module word_fifo
    import message_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_strobe,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_pop,
    output logic             read_valid,
    output logic [WIDTH-1:0] read_data,
    output logic             full,
    output logic             overflow
);

    localparam int LOG_DEPTH = clog2(DEPTH);
    localparam logic [LOG_DEPTH:0] FULL_LEVEL = (LOG_DEPTH + 1)'(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_reg;
    logic [LOG_DEPTH-1:0] rd_ptr_reg;
    logic [LOG_DEPTH:0]   level_reg;
    logic                 do_pop;
    logic                 do_push;

    assign read_valid = (level_reg != '0);
    assign full       = (level_reg == FULL_LEVEL);
    assign do_pop     = read_pop && read_valid;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push    = write_strobe && (!full || do_pop);
    assign overflow   = write_strobe && full && !do_pop;
    assign read_data  = read_valid ? mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/message_stitcher.sv
// Reassembles N_SLICES narrow slices (MS slice first) into wide words behind an output FIFO.
// Optional STITCHER_ALIGN_CHECK_EN realigns on in_first and flags framing errors.
module message_stitcher
    import message_pkg::*;
#(
    parameter int N_SLICES      = 2,
    parameter int WIDTH         = 32,
    parameter int BUFFER_LENGTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_nd,
    input  logic                        in_first,
    output logic [WIDTH*N_SLICES-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        error
);

    localparam int LOG_N_SLICES      = clog2(N_SLICES);
    localparam int LOG_BUFFER_LENGTH = clog2(BUFFER_LENGTH);
    localparam int WORD_W            = WIDTH * N_SLICES;
    localparam int UPPER_W           = WIDTH * (N_SLICES - 1);
    localparam logic [LOG_N_SLICES-1:0] POS_TOP = LOG_N_SLICES'(N_SLICES - 1);

    logic [LOG_N_SLICES-1:0] pos_reg, pos_next;
    logic [UPPER_W-1:0]      asm_reg, asm_next;
    logic                    error_reg;
    logic                    accept;
    logic                    restart;
    logic                    align_err;
    logic                    push;
    logic [WORD_W-1:0]       push_word;
    logic                    overflow;
    logic                    unused_full;

    // Framing decision: whether this slice joins the current word, restarts it, or is dropped.
    always_comb begin
        accept    = in_nd;
        restart   = 1'b0;
        align_err = 1'b0;
`ifdef STITCHER_ALIGN_CHECK_EN
        if (in_nd && in_first && pos_reg != POS_TOP) begin
            accept    = 1'b0;
            restart   = 1'b1;
            align_err = 1'b1;
        end else if (in_nd && !in_first && pos_reg == POS_TOP) begin
            accept    = 1'b0;
            align_err = 1'b1;
        end
`endif
    end

`ifndef STITCHER_ALIGN_CHECK_EN
    logic unused_first;
    assign unused_first = in_first;
`endif

    // Only the upper slices are held; the last slice goes straight into the FIFO word.
    always_comb begin
        pos_next  = pos_reg;
        asm_next  = asm_reg;
        push      = 1'b0;
        push_word = {asm_reg, in_data};
        if (restart) begin
            asm_next                       = '0;
            asm_next[UPPER_W-1 -: WIDTH]   = in_data;
            pos_next                       = POS_TOP - 1'b1;
        end else if (accept) begin
            if (pos_reg == '0) begin
                push     = 1'b1;
                pos_next = POS_TOP;
            end else begin
                asm_next[WIDTH*(int'(pos_reg) - 1) +: WIDTH] = in_data;
                pos_next = pos_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_reg   <= POS_TOP;
            asm_reg   <= '0;
            error_reg <= 1'b0;
        end else begin
            pos_reg   <= pos_next;
            asm_reg   <= asm_next;
            error_reg <= error_reg | align_err | overflow;
        end
    end

    assign error = error_reg;

    word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (1 << LOG_BUFFER_LENGTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .write_strobe (push),
        .write_data   (push_word),
        .read_pop     (out_ready),
        .read_valid   (out_valid),
        .read_data    (out_data),
        .full         (unused_full),
        .overflow     (overflow)
    );

endmodule
